// File: rtl/game_pkg.sv
// Shared game definitions: round states, key indices, mux colours and a counter-width helper.
package game_pkg;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_GAME  = 2'd1,
    ST_WIN   = 2'd2,
    ST_LOSE  = 2'd3
  } state_t;

  localparam int unsigned KEY_UP = 0;
  localparam int unsigned KEY_LF = 1;
  localparam int unsigned KEY_RT = 2;
  localparam int unsigned KEY_ET = 3;

  localparam logic [11:0] COL_START = 12'h00F;
  localparam logic [11:0] COL_GAME  = 12'h0F0;
  localparam logic [11:0] COL_WIN   = 12'hFF0;
  localparam logic [11:0] COL_LOSE  = 12'hF00;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/game_flow_ctrl_sync_rise.sv
// Two-flop synchroniser followed by a registered rising-edge detector (3-cycle latency).
module sync_rise (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
      rise <= sync & ~prev;
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Round-level controller: START/GAME/WIN/LOSE flow with lives, countdown timer,
// post-hit invulnerability window and a round-restart pulse for the sprites.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int unsigned LIVES_INIT     = 3,
  parameter int unsigned TIME_INIT      = 120,
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned INVULN_FRAMES  = 90
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enter_key,
  input  logic       win_evt,
  input  logic       lose_evt,
  input  logic       frame_tick,
  output logic [1:0] state,
  output logic [1:0] lives,
  output logic [7:0] time_left,
  output logic       round_start,
  output logic       invuln
);

  localparam int unsigned SEC_W = cnt_w(FRAMES_PER_SEC);
  localparam int unsigned INV_W = cnt_w(INVULN_FRAMES + 1);
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(FRAMES_PER_SEC - 1);
  localparam logic [INV_W-1:0] INV_LOAD = INV_W'(INVULN_FRAMES);

  logic enter_rise;
  logic win_rise;
  logic lose_rise;

  sync_rise u_enter (.clk(clk), .rst(rst), .din(enter_key), .rise(enter_rise));
  sync_rise u_win   (.clk(clk), .rst(rst), .din(win_evt),   .rise(win_rise));
  sync_rise u_lose  (.clk(clk), .rst(rst), .din(lose_evt),  .rise(lose_rise));

  state_t           state_q, state_d;
  logic [1:0]       lives_d;
  logic [7:0]       time_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic [INV_W-1:0] inv_cnt_q, inv_cnt_d;
  logic             invuln_d;
  logic             round_start_d;
  logic             sec_wrap;

  assign state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_START;
      lives       <= 2'd0;
      time_left   <= 8'd0;
      sec_q       <= '0;
      inv_cnt_q   <= '0;
      invuln      <= 1'b0;
      round_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives       <= lives_d;
      time_left   <= time_d;
      sec_q       <= sec_d;
      inv_cnt_q   <= inv_cnt_d;
      invuln      <= invuln_d;
      round_start <= round_start_d;
    end
  end

  // Win beats a hit, a hit beats the timer; WIN/LOSE hold everything until enter.
  always_comb begin
    state_d       = state_q;
    lives_d       = lives;
    time_d        = time_left;
    sec_d         = sec_q;
    inv_cnt_d     = inv_cnt_q;
    invuln_d      = invuln;
    round_start_d = 1'b0;
    sec_wrap      = (sec_q == SEC_LAST);

    case (state_q)
      ST_START: begin
        if (enter_rise) begin
          state_d       = ST_GAME;
          lives_d       = 2'(LIVES_INIT);
          time_d        = 8'(TIME_INIT);
          sec_d         = '0;
          inv_cnt_d     = '0;
          invuln_d      = 1'b0;
          round_start_d = 1'b1;
        end
      end

      ST_GAME: begin
        if (win_rise) begin
          state_d = ST_WIN;
        end else if (lose_rise && !invuln) begin
          if (lives == 2'd1) begin
            lives_d = 2'd0;
            state_d = ST_LOSE;
          end else begin
            lives_d       = lives - 2'd1;
            invuln_d      = (INVULN_FRAMES != 0);
            inv_cnt_d     = INV_LOAD;
            round_start_d = 1'b1;
          end
        end else begin
          if (frame_tick) begin
            sec_d = sec_wrap ? '0 : sec_q + SEC_W'(1);
            if (sec_wrap && time_left != 8'd0) begin
              time_d = time_left - 8'd1;
              if (time_left == 8'd1) state_d = ST_LOSE;
            end
            if (inv_cnt_q != '0) inv_cnt_d = inv_cnt_q - INV_W'(1);
          end
          // Window closes the cycle after the counter has drained.
          if (invuln && inv_cnt_q == '0) invuln_d = 1'b0;
        end
      end

      ST_WIN, ST_LOSE: begin
        if (enter_rise) state_d = ST_START;
      end
    endcase
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: default-parameter instance for flow/lives/priority,
// a short-timer instance for countdown expiry.
module tb_game_flow_ctrl;

  logic clk;
  logic rst;
  logic enter_a;
  logic enter_b;
  logic win_evt;
  logic lose_evt;
  logic frame_tick;

  logic [1:0] a_state, b_state;
  logic [1:0] a_lives, b_lives;
  logic [7:0] a_time, b_time;
  logic       a_rs, b_rs;
  logic       a_inv, b_inv;

  int n_tests;
  int n_fail;

  game_flow_ctrl u_dut (
    .clk(clk), .rst(rst), .enter_key(enter_a), .win_evt(win_evt), .lose_evt(lose_evt),
    .frame_tick(frame_tick), .state(a_state), .lives(a_lives), .time_left(a_time),
    .round_start(a_rs), .invuln(a_inv)
  );

  game_flow_ctrl #(.TIME_INIT(2), .FRAMES_PER_SEC(4)) u_tmr (
    .clk(clk), .rst(rst), .enter_key(enter_b), .win_evt(win_evt), .lose_evt(lose_evt),
    .frame_tick(frame_tick), .state(b_state), .lives(b_lives), .time_left(b_time),
    .round_start(b_rs), .invuln(b_inv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
      cyc(1);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0; enter_a = 1'b0; enter_b = 1'b0;
    win_evt = 1'b0; lose_evt = 1'b0; frame_tick = 1'b0;

    // Reset values
    cyc(3);
    check("rst_state", 32'(a_state), 0);
    check("rst_lives", 32'(a_lives), 0);
    check("rst_time",  32'(a_time), 0);
    check("rst_rs",    32'(a_rs), 0);
    check("rst_inv",   32'(a_inv), 0);
    rst = 1'b1;
    cyc(2);

    // Enter: GAME exactly 4 cycles after the rise
    enter_a = 1'b1;
    cyc(3);
    check("enter_lat3_state", 32'(a_state), 0);
    cyc(1);
    check("enter_state", 32'(a_state), 1);
    check("enter_lives", 32'(a_lives), 3);
    check("enter_time",  32'(a_time), 120);
    check("enter_rs",    32'(a_rs), 1);
    cyc(1);
    check("enter_rs_1cyc", 32'(a_rs), 0);
    enter_a = 1'b0;
    cyc(4);

    // First hit
    lose_evt = 1'b1;
    cyc(4);
    check("hit1_lives", 32'(a_lives), 2);
    check("hit1_inv",   32'(a_inv), 1);
    check("hit1_rs",    32'(a_rs), 1);
    check("hit1_time",  32'(a_time), 120);
    cyc(1);
    check("hit1_rs_1cyc", 32'(a_rs), 0);
    lose_evt = 1'b0;
    frames(10);

    // Hit inside the window is discarded
    lose_evt = 1'b1;
    cyc(4);
    check("hit2_ignored_lives", 32'(a_lives), 2);
    check("hit2_ignored_rs",    32'(a_rs), 0);
    lose_evt = 1'b0;
    frames(79);
    check("inv_89_frames", 32'(a_inv), 1);
    frames(1);
    check("inv_90_frames", 32'(a_inv), 0);
    check("time_after_90", 32'(a_time), 119);

    // Hit outside the window
    lose_evt = 1'b1;
    cyc(4);
    check("hit3_lives", 32'(a_lives), 1);
    check("hit3_inv",   32'(a_inv), 1);
    check("hit3_rs",    32'(a_rs), 1);
    lose_evt = 1'b0;
    frames(90);
    check("inv2_clear", 32'(a_inv), 0);

    // Last life lost
    lose_evt = 1'b1;
    cyc(4);
    check("last_state", 32'(a_state), 3);
    check("last_lives", 32'(a_lives), 0);
    check("last_time",  32'(a_time), 117);
    check("last_rs",    32'(a_rs), 0);
    lose_evt = 1'b0;
    frames(60);
    check("lose_frozen_time", 32'(a_time), 117);
    enter_a = 1'b1;
    cyc(4);
    check("lose_to_start",   32'(a_state), 0);
    check("start_kept_lives", 32'(a_lives), 0);
    check("start_kept_time",  32'(a_time), 117);
    enter_a = 1'b0;
    cyc(4);

    // Win and lose in the same cycle: win wins
    enter_a = 1'b1;
    cyc(4);
    check("reload_state", 32'(a_state), 1);
    check("reload_lives", 32'(a_lives), 3);
    check("reload_time",  32'(a_time), 120);
    enter_a = 1'b0;
    cyc(4);
    win_evt = 1'b1;
    lose_evt = 1'b1;
    cyc(4);
    check("prio_state", 32'(a_state), 2);
    check("prio_lives", 32'(a_lives), 3);
    check("prio_inv",   32'(a_inv), 0);
    win_evt = 1'b0;
    lose_evt = 1'b0;
    enter_a = 1'b1;
    cyc(4);
    check("win_to_start", 32'(a_state), 0);

    // Held enter key does not skip states
    enter_a = 1'b0;
    cyc(4);
    enter_a = 1'b1;
    cyc(4);
    check("held_game", 32'(a_state), 1);
    win_evt = 1'b1;
    cyc(4);
    check("held_win", 32'(a_state), 2);
    cyc(10);
    check("held_stays_win", 32'(a_state), 2);
    win_evt = 1'b0;
    enter_a = 1'b0;
    cyc(4);
    check("release_stays_win", 32'(a_state), 2);
    enter_a = 1'b1;
    cyc(4);
    check("repress_start", 32'(a_state), 0);

    // Asynchronous reset mid-round with invulnerability active
    enter_a = 1'b0;
    cyc(4);
    enter_a = 1'b1;
    cyc(4);
    enter_a = 1'b0;
    lose_evt = 1'b1;
    cyc(4);
    check("pre_rst_inv",   32'(a_inv), 1);
    check("pre_rst_lives", 32'(a_lives), 2);
    #2;
    rst = 1'b0;
    #1;
    check("async_state", 32'(a_state), 0);
    check("async_lives", 32'(a_lives), 0);
    check("async_time",  32'(a_time), 0);
    check("async_inv",   32'(a_inv), 0);
    check("async_rs",    32'(a_rs), 0);
    lose_evt = 1'b0;
    cyc(2);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      check("post_rst_no_rs", 32'(a_rs), 0);
      check("post_rst_state", 32'(a_state), 0);
    end

    // Countdown expiry on the short-timer instance
    enter_b = 1'b1;
    cyc(4);
    check("tmr_game", 32'(b_state), 1);
    check("tmr_time", 32'(b_time), 2);
    enter_b = 1'b0;
    frames(4);
    check("tmr_4ticks", 32'(b_time), 1);
    frames(3);
    check("tmr_7ticks_time",  32'(b_time), 1);
    check("tmr_7ticks_state", 32'(b_state), 1);
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    check("tmr_expire_time",  32'(b_time), 0);
    check("tmr_expire_state", 32'(b_state), 3);
    check("tmr_expire_lives", 32'(b_lives), 3);
    frames(8);
    check("tmr_no_wrap", 32'(b_time), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
